// File: rtl/dual_issue_queue_pkg.sv
// Shared types for the dual-issue instruction queue: decoded packet layout,
// pairing split reasons and the hard-wired zero register.
package dual_issue_queue_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        lw;
    logic        sw;
    logic        branch;
  } pkt_t;

  typedef enum logic [1:0] {
    SPLIT_NONE = 2'd0,
    SPLIT_RAW  = 2'd1,
    SPLIT_MEM  = 2'd2,
    SPLIT_CTRL = 2'd3
  } split_e;

endpackage

// File: rtl/dual_issue_queue_if.sv
// Fetch-side enqueue and decode-side issue bundle of the dual-issue queue.
interface dual_issue_queue_if;
  import dual_issue_queue_pkg::*;

  // Enqueue transfers at posedge when enq_valid[0] & enq_ready (lane1 only with lane0);
  // issue has no ready: the consumer holds it back with the top-level stall input.
  logic [1:0]       enq_valid;
  pkt_t [1:0]       enq_pkt;
  logic             enq_ready;
  logic [1:0]       issue_valid;
  pkt_t [1:0]       issue_pkt;
  split_e           split_reason;

  modport master (
    output enq_valid, enq_pkt,
    input  enq_ready, issue_valid, issue_pkt, split_reason
  );

  modport slave (
    input  enq_valid, enq_pkt,
    output enq_ready, issue_valid, issue_pkt, split_reason
  );

endinterface

// File: rtl/dual_issue_queue_pair_check.sv
// Combinational pairing rules for an older (a) / younger (b) instruction pair.
module dual_issue_queue_pair_check
  import dual_issue_queue_pkg::*;
(
  input  pkt_t   a,
  input  pkt_t   b,
  output logic   pair_ok,
  output split_e reason
);

  logic raw;
  logic waw;
  logic mem_conflict;
  logic ctrl;
  logic unused_fields;

  assign raw          = a.regwrite && (a.wreg != REG_ZERO) &&
                        ((a.wreg == b.rs) || (a.wreg == b.rt));
  assign waw          = a.regwrite && b.regwrite && (a.wreg == b.wreg) && (a.wreg != REG_ZERO);
  assign mem_conflict = (a.lw || a.sw) && (b.lw || b.sw);
  // A branch must occupy slot A so that its delay slot can follow it.
  assign ctrl         = b.branch;

  assign unused_fields = ^{a.pc, a.instr, a.rs, a.rt, a.branch, b.pc, b.instr};

  always_comb begin
    reason = SPLIT_NONE;
    if (raw || waw)        reason = SPLIT_RAW;
    else if (mem_conflict) reason = SPLIT_MEM;
    else if (ctrl)         reason = SPLIT_CTRL;
  end

  assign pair_ok = (reason == SPLIT_NONE);

endmodule

// File: rtl/dual_issue_queue.sv
// Decoded-instruction queue feeding two in-order issue slots, with saturating
// single/dual-issue performance counters.
module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   stall,
  dual_issue_queue_if.slave      q,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       single_cnt,
  output logic [CNT_W-1:0]       dual_cnt
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [PW:0] ONE       = (PW+1)'(1);
  localparam logic [PW:0] TWO       = (PW+1)'(2);
  localparam logic [PW:0] READY_MAX = (PW+1)'(DEPTH - 2);

  pkt_t          mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_nx;
  logic          enq_fire;
  logic [PW:0]   enq_n;
  logic [PW:0]   deq_n;
  logic          can_issue;
  logic          has_pair;
  logic          iv_a;
  logic          iv_b;
  logic          pair_ok;
  split_e        reason;

  assign head_nx = head + PW'(1);

  // Ready looks only at the registered count so it never depends on this cycle's issue.
  assign q.enq_ready = !reset && (count <= READY_MAX);
  assign enq_fire    = q.enq_ready && q.enq_valid[0] && !flush;
  assign enq_n       = !enq_fire ? '0 : (q.enq_valid[1] ? TWO : ONE);

  assign can_issue = (count != '0) && !stall && !flush;
  assign has_pair  = can_issue && (count >= TWO);
  assign iv_a      = can_issue;
  assign iv_b      = has_pair && (ISSUE_WIDTH == 2) && pair_ok;
  assign deq_n     = {PW'(0), iv_a} + {PW'(0), iv_b};

  assign q.issue_valid  = {iv_b, iv_a};
  assign q.split_reason = has_pair ? reason : SPLIT_NONE;
  assign q.issue_pkt    = {(count >= TWO)  ? mem[head_nx] : '0,
                           (count != '0)   ? mem[head]    : '0};

  dual_issue_queue_pair_check u_pair (
    .a       (mem[head]),
    .b       (mem[head_nx]),
    .pair_ok (pair_ok),
    .reason  (reason)
  );

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail] <= q.enq_pkt[0];
      if (q.enq_valid[1]) mem[tail + PW'(1)] <= q.enq_pkt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      single_cnt <= '0;
      dual_cnt   <= '0;
    end else begin
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + deq_n[PW-1:0];
        tail  <= tail + enq_n[PW-1:0];
        count <= count + enq_n - deq_n;
      end
      if (iv_b) begin
        if (dual_cnt != '1) dual_cnt <= dual_cnt + CNT_W'(1);
      end else if (iv_a) begin
        if (single_cnt != '1) single_cnt <= single_cnt + CNT_W'(1);
      end
    end
  end

  lane1_needs_lane0: assert property (@(posedge clk) disable iff (reset) q.enq_valid != 2'b10);

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: a dual-issue instance plus a scalar
// instance with 3-bit counters; issue order is scoreboarded per instance.
module tb_dual_issue_queue;
  import dual_issue_queue_pkg::*;

  localparam int W     = $bits(pkt_t);
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, reset1, flush, flush1, stall, stall1;
  logic [CW-1:0] count, count1;
  logic [31:0]   single_cnt, dual_cnt;
  logic [2:0]    single_cnt1, dual_cnt1;

  dual_issue_queue_if bus ();
  dual_issue_queue_if bus1 ();

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  logic [31:0]  next_pc = 32'h1000;

  always #5 clk = ~clk;

  dual_issue_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(2), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall), .q(bus),
    .count(count), .single_cnt(single_cnt), .dual_cnt(dual_cnt)
  );

  dual_issue_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(reset1), .flush(flush1), .stall(stall1), .q(bus1),
    .count(count1), .single_cnt(single_cnt1), .dual_cnt(dual_cnt1)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wreg,
                              input logic rw, input logic lw, input logic sw, input logic br);
    pkt_t p;
    p.pc       = next_pc;
    next_pc    = next_pc + 32'd4;
    p.instr    = 32'($urandom_range(65535, 0));
    p.rs       = rs;
    p.rt       = rt;
    p.wreg     = wreg;
    p.regwrite = rw;
    p.lw       = lw;
    p.sw       = sw;
    p.branch   = br;
    return p;
  endfunction

  function automatic pkt_t alu(input logic [4:0] wreg, input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, wreg, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // ---------------- scoreboard monitors ----------------
  initial begin : mon_dual
    forever begin
      @(negedge clk);
      #2;
      if (bus.issue_valid == 2'b10) check("b_implies_a", W'(bus.issue_valid), W'(2'b11));
      for (int i = 0; i < 2; i++) begin
        if (bus.issue_valid[i]) begin
          if (exp_q.size() == 0) check("issue_underflow", W'(exp_q.size()), W'(1));
          else check(i == 0 ? "slot_a_pkt" : "slot_b_pkt", bus.issue_pkt[i], exp_q.pop_front());
        end
      end
    end
  end

  initial begin : mon_scalar
    forever begin
      @(negedge clk);
      #2;
      if (bus1.issue_valid != 2'b00) begin
        check("scalar_iv", W'(bus1.issue_valid), W'(2'b01));
        if (exp1_q.size() == 0) check("scalar_underflow", W'(exp1_q.size()), W'(1));
        else check("scalar_pkt", bus1.issue_pkt[0], exp1_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input pkt_t a, input pkt_t b, input bit push);
    bus.enq_valid  = v;
    bus.enq_pkt[0] = a;
    bus.enq_pkt[1] = b;
    if (push) begin
      exp_q.push_back(a);
      if (v[1]) exp_q.push_back(b);
    end
  endtask

  task automatic drive1(input pkt_t a, input pkt_t b);
    bus1.enq_valid  = 2'b11;
    bus1.enq_pkt[0] = a;
    bus1.enq_pkt[1] = b;
    exp1_q.push_back(a);
    exp1_q.push_back(b);
  endtask

  task automatic idle();
    bus.enq_valid  = 2'b00;
    bus1.enq_valid = 2'b00;
  endtask

  // Enqueue one pair into an empty queue and check how it issues.
  task automatic run_pair(input string tag, input pkt_t a, input pkt_t b,
                          input logic [1:0] exp_iv, input split_e exp_split);
    drive(2'b11, a, b, 1'b1);
    cyc();
    idle();
    check({tag, "_iv"}, W'(bus.issue_valid), W'(exp_iv));
    check({tag, "_split"}, W'(bus.split_reason), W'(exp_split));
    if (exp_iv == 2'b01) begin
      cyc();
      check({tag, "_b_alone"}, W'(bus.issue_valid), W'(2'b01));
      check({tag, "_b_alone_split"}, W'(bus.split_reason), W'(SPLIT_NONE));
    end
    cyc();
    check({tag, "_drained"}, W'(count), W'(0));
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 12 && count != '0; k++) cyc();
    check({tag, "_count"}, W'(count), W'(0));
    check({tag, "_sb_empty"}, W'(exp_q.size()), W'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    pkt_t p;
    reset = 1'b1; reset1 = 1'b1;
    flush = 1'b0; flush1 = 1'b0;
    stall = 1'b0; stall1 = 1'b0;
    bus.enq_valid  = 2'b00; bus.enq_pkt  = '0;
    bus1.enq_valid = 2'b00; bus1.enq_pkt = '0;
    repeat (2) cyc();
    check("rst_count", W'(count), W'(0));
    check("rst_iv", W'(bus.issue_valid), W'(0));
    check("rst_ready", W'(bus.enq_ready), W'(0));
    check("rst_pkt", W'(bus.issue_pkt), W'(0));
    check("rst_cnts", W'({single_cnt, dual_cnt}), W'(0));
    reset = 1'b0; reset1 = 1'b0;
    cyc();
    check("ready_after_rst", W'(bus.enq_ready), W'(1));

    // Pairing rules, each on an empty queue.
    run_pair("indep", alu(3, 1, 2), alu(4, 1, 2), 2'b11, SPLIT_NONE);
    check("t1_dual_cnt", W'(dual_cnt), W'(1));
    run_pair("raw", alu(5, 1, 2), alu(7, 5, 6), 2'b01, SPLIT_RAW);
    run_pair("r0_write", alu(0, 1, 2), alu(7, 0, 6), 2'b11, SPLIT_NONE);
    run_pair("waw", alu(8, 1, 2), alu(8, 3, 4), 2'b01, SPLIT_RAW);
    run_pair("mem", mk(1, 9, 9, 1'b1, 1'b1, 1'b0, 1'b0), mk(1, 10, 0, 1'b0, 1'b0, 1'b1, 1'b0),
             2'b01, SPLIT_MEM);
    run_pair("br_delay", mk(1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1), alu(11, 3, 4), 2'b11, SPLIT_NONE);
    run_pair("ctrl", alu(12, 1, 2), mk(3, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1), 2'b01, SPLIT_CTRL);
    run_pair("raw_over_mem", mk(1, 9, 9, 1'b1, 1'b1, 1'b0, 1'b0),
             mk(1, 9, 0, 1'b0, 1'b0, 1'b1, 1'b0), 2'b01, SPLIT_RAW);
    check("pair_single_cnt", W'(single_cnt), W'(10));
    check("pair_dual_cnt", W'(dual_cnt), W'(3));

    // Single-entry queue: slot B must stay idle; also moves head off zero.
    for (int i = 0; i < 3; i++) begin
      p = (i == 1) ? mk(1, 13, 13, 1'b1, 1'b1, 1'b0, 1'b0) : alu(5'(13 + i), 1, 2);
      drive(2'b01, p, p, 1'b1);
      cyc();
      idle();
      check("one_entry_iv", W'(bus.issue_valid), W'(2'b01));
      check("one_entry_split", W'(bus.split_reason), W'(SPLIT_NONE));
      cyc();
    end
    check("one_entry_single_cnt", W'(single_cnt), W'(13));

    // Fill under stall until full at DEPTH-1, then drain across the wrap.
    stall = 1'b1;
    drive(2'b01, alu(16, 1, 2), alu(16, 1, 2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) check("ready_at_5", W'({count, bus.enq_ready}), W'({4'd5, 1'b1}));
      drive(2'b11, alu(5'(17 + 2 * i), 1, 2), alu(5'(18 + 2 * i), 1, 2), 1'b1);
    end
    cyc();
    check("full_count", W'(count), W'(7));
    check("full_ready", W'(bus.enq_ready), W'(0));
    check("stall_iv", W'(bus.issue_valid), W'(0));
    check("stall_split", W'(bus.split_reason), W'(SPLIT_NONE));
    drive(2'b11, alu(30, 1, 2), alu(31, 1, 2), 1'b0);
    cyc();
    idle();
    check("full_no_enq", W'(count), W'(7));
    stall = 1'b0;
    drain("wrap_drain");
    check("wrap_single_cnt", W'(single_cnt), W'(14));
    check("wrap_dual_cnt", W'(dual_cnt), W'(6));

    // Flush with count=5 and a same-cycle enqueue attempt.
    stall = 1'b1;
    drive(2'b01, alu(20, 1, 2), alu(20, 1, 2), 1'b1);
    cyc();
    drive(2'b11, alu(21, 1, 2), alu(22, 1, 2), 1'b1);
    cyc();
    drive(2'b11, alu(23, 1, 2), alu(24, 1, 2), 1'b1);
    cyc();
    check("pre_flush_count", W'(count), W'(5));
    stall = 1'b0;
    flush = 1'b1;
    drive(2'b11, alu(25, 1, 2), alu(26, 1, 2), 1'b0);
    exp_q.delete();
    #1;
    check("flush_iv", W'(bus.issue_valid), W'(0));
    check("flush_split", W'(bus.split_reason), W'(SPLIT_NONE));
    cyc();
    flush = 1'b0;
    idle();
    check("post_flush_count", W'(count), W'(0));
    check("post_flush_iv", W'(bus.issue_valid), W'(0));
    check("flush_cnts", W'({single_cnt, dual_cnt}), W'({32'd14, 32'd6}));
    run_pair("post_flush", alu(3, 1, 2), alu(4, 1, 2), 2'b11, SPLIT_NONE);
    check("post_flush_dual_cnt", W'(dual_cnt), W'(7));

    // Scalar instance: one issue per cycle, 3-bit counter saturates.
    stall1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive1(alu(5'(1 + 2 * i), 8, 9), alu(5'(2 + 2 * i), 8, 9));
      cyc();
    end
    idle();
    check("scalar_fill", W'(count1), W'(6));
    stall1 = 1'b0;
    cyc();
    check("scalar_first_iv", W'(bus1.issue_valid), W'(2'b01));
    for (int k = 0; k < 12 && count1 != '0; k++) cyc();
    check("scalar_single_6", W'(single_cnt1), W'(6));
    drive1(alu(20, 8, 9), alu(21, 8, 9));
    cyc();
    idle();
    for (int k = 0; k < 6 && count1 != '0; k++) cyc();
    cyc();
    check("scalar_saturate", W'(single_cnt1), W'(7));
    check("scalar_dual_zero", W'(dual_cnt1), W'(0));
    check("scalar_sb_empty", W'(exp1_q.size()), W'(0));

    // Reset mid-stream clears the scalar instance without waiting for a clock.
    drive1(alu(22, 8, 9), alu(23, 8, 9));
    cyc();
    drive1(alu(24, 8, 9), alu(25, 8, 9));
    #1;
    exp1_q.delete();
    reset1 = 1'b1;
    #1;
    check("midrst_iv", W'(bus1.issue_valid), W'(0));
    check("midrst_count", W'(count1), W'(0));
    check("midrst_cnts", W'({single_cnt1, dual_cnt1}), W'(0));
    check("midrst_ready", W'(bus1.enq_ready), W'(0));
    check("midrst_pkt", W'(bus1.issue_pkt), W'(0));
    check("midrst_split", W'(bus1.split_reason), W'(SPLIT_NONE));
    cyc();
    idle();
    reset1 = 1'b0;
    cyc();
    check("after_midrst", W'({count1, bus1.enq_ready}), W'({4'd0, 1'b1}));

    check("final_sb_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
